// File: rtl/obi_axi_lite_bridge.sv
// obi_axi_lite_bridge: OBI subordinate to AXI4-Lite manager bridge.
// Accepts up to MaxOutstanding OBI transactions. The type of each accepted
// transaction is remembered in order, so OBI responses come back strictly in
// request order even when B and R beats arrive in a different order.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   obi_*                    OBI subordinate: req/gnt, addr/we/be/wdata, rvalid/rdata/err
//   aw_*, w_*, b_*           AXI4-Lite write channels (manager side)
//   ar_*, r_*                AXI4-Lite read channels (manager side)
//   busy_o, outstanding_o    outstanding-transaction status
module obi_axi_lite_bridge #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [2:0]  AxiProt        = 3'b000
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   obi_req_i,
    output logic                                   obi_gnt_o,
    input  logic [AddrWidth-1:0]                   obi_addr_i,
    input  logic                                   obi_we_i,
    input  logic [DataWidth/8-1:0]                 obi_be_i,
    input  logic [DataWidth-1:0]                   obi_wdata_i,
    output logic                                   obi_rvalid_o,
    output logic [DataWidth-1:0]                   obi_rdata_o,
    output logic                                   obi_err_o,
    output logic                                   aw_valid_o,
    input  logic                                   aw_ready_i,
    output logic [AddrWidth-1:0]                   aw_addr_o,
    output logic [2:0]                             aw_prot_o,
    output logic                                   w_valid_o,
    input  logic                                   w_ready_i,
    output logic [DataWidth-1:0]                   w_data_o,
    output logic [DataWidth/8-1:0]                 w_strb_o,
    input  logic                                   b_valid_i,
    output logic                                   b_ready_o,
    input  logic [1:0]                             b_resp_i,
    output logic                                   ar_valid_o,
    input  logic                                   ar_ready_i,
    output logic [AddrWidth-1:0]                   ar_addr_o,
    output logic [2:0]                             ar_prot_o,
    input  logic                                   r_valid_i,
    output logic                                   r_ready_o,
    input  logic [DataWidth-1:0]                   r_data_i,
    input  logic [1:0]                             r_resp_i,
    output logic                                   busy_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrWidth  = $clog2(MaxOutstanding);

    logic                      aw_valid_q, aw_valid_d;
    logic [AddrWidth-1:0]      aw_addr_q,  aw_addr_d;
    logic                      w_valid_q,  w_valid_d;
    logic [DataWidth-1:0]      w_data_q,   w_data_d;
    logic [StrbWidth-1:0]      w_strb_q,   w_strb_d;
    logic                      ar_valid_q, ar_valid_d;
    logic [AddrWidth-1:0]      ar_addr_q,  ar_addr_d;
    logic [CntWidth-1:0]       cnt_q,      cnt_d;
    logic [MaxOutstanding-1:0] fifo_q,     fifo_d;
    logic [PtrWidth-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PtrWidth-1:0]       rd_ptr_q,   rd_ptr_d;
    logic                      rvalid_q,   rvalid_d;
    logic [DataWidth-1:0]      rdata_q,    rdata_d;
    logic                      err_q,      err_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, resp_hs;
    logic fifo_nonempty, head_is_wr, cnt_ok, wr_free, rd_free;
    logic accept, accept_wr, accept_rd;

    // Only resp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
    logic unused_resp_lsb;
    assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

    // FIFO occupancy equals the outstanding count, so cnt doubles as "nonempty".
    assign fifo_nonempty = (cnt_q != '0);
    assign head_is_wr    = fifo_q[rd_ptr_q];
    assign b_ready_o     = fifo_nonempty & head_is_wr;
    assign r_ready_o     = fifo_nonempty & ~head_is_wr;

    assign aw_hs   = aw_valid_q & aw_ready_i;
    assign w_hs    = w_valid_q  & w_ready_i;
    assign ar_hs   = ar_valid_q & ar_ready_i;
    assign b_hs    = b_valid_i  & b_ready_o;
    assign r_hs    = r_valid_i  & r_ready_o;
    assign resp_hs = b_hs | r_hs;

    // Grant: room for another outstanding entry and the target request registers free.
    assign cnt_ok    = (cnt_q < CntWidth'(MaxOutstanding));
    assign wr_free   = (~aw_valid_q | aw_ready_i) & (~w_valid_q | w_ready_i);
    assign rd_free   = ~ar_valid_q | ar_ready_i;
    assign obi_gnt_o = obi_req_i & cnt_ok & (obi_we_i ? wr_free : rd_free);
    assign accept    = obi_gnt_o;
    assign accept_wr = accept & obi_we_i;
    assign accept_rd = accept & ~obi_we_i;

    // Next-state logic for request registers, order FIFO, counter and OBI response.
    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        w_valid_d  = w_valid_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        ar_valid_d = ar_valid_q;
        ar_addr_d  = ar_addr_q;
        cnt_d      = cnt_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rvalid_d   = resp_hs;
        rdata_d    = rdata_q;
        err_d      = err_q;

        if (aw_hs) aw_valid_d = 1'b0;
        if (w_hs)  w_valid_d  = 1'b0;
        if (ar_hs) ar_valid_d = 1'b0;

        // A new accept overrides a same-cycle handshake clear.
        if (accept_wr) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = obi_addr_i;
            w_valid_d  = 1'b1;
            w_data_d   = obi_wdata_i;
            w_strb_d   = obi_be_i;
        end
        if (accept_rd) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = obi_addr_i;
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = obi_we_i;
            wr_ptr_d         = wr_ptr_q + PtrWidth'(1);
        end
        if (resp_hs) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        case ({accept, resp_hs})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase

        if (r_hs) begin
            rdata_d = r_data_i;
            err_d   = r_resp_i[1];
        end else if (b_hs) begin
            rdata_d = '0;
            err_d   = b_resp_i[1];
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            cnt_q      <= '0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_valid_q  <= w_valid_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign aw_valid_o    = aw_valid_q;
    assign aw_addr_o     = aw_addr_q;
    assign aw_prot_o     = AxiProt;
    assign w_valid_o     = w_valid_q;
    assign w_data_o      = w_data_q;
    assign w_strb_o      = w_strb_q;
    assign ar_valid_o    = ar_valid_q;
    assign ar_addr_o     = ar_addr_q;
    assign ar_prot_o     = AxiProt;
    assign obi_rvalid_o  = rvalid_q;
    assign obi_rdata_o   = rdata_q;
    assign obi_err_o     = err_q;
    assign busy_o        = fifo_nonempty;
    assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_obi_axi_lite_bridge.sv
// tb_obi_axi_lite_bridge: directed self-checking bench for obi_axi_lite_bridge
// (default parameters: 32-bit address/data, MaxOutstanding = 4).
module tb_obi_axi_lite_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_err;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
    logic        ar_valid, ar_ready, r_valid, r_ready;
    logic [31:0] aw_addr, ar_addr, w_data, r_data;
    logic [3:0]  w_strb;
    logic [2:0]  aw_prot, ar_prot;
    logic [1:0]  b_resp, r_resp;
    logic        busy;
    logic [2:0]  outstanding;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    obi_axi_lite_bridge dut (
        .clk_i(clk), .rst_ni(rst_n),
        .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
        .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
        .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_prot_o(aw_prot),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_prot_o(ar_prot),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
        .busy_o(busy), .outstanding_o(outstanding)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, obi_rvalid} !== 6'b0) begin n_err++; $display("FAIL rst_valids: got %b want 000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, obi_rvalid}); end
        n_cmp++; if ({busy, outstanding, obi_err} !== 5'b0) begin n_err++; $display("FAIL rst_status: got busy=%0b cnt=%0d err=%0b want 0", busy, outstanding, obi_err); end
        n_cmp++; if (obi_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", obi_rdata); end
        n_cmp++; if ({aw_addr, ar_addr, w_data, w_strb} !== 100'h0) begin n_err++; $display("FAIL rst_regs: got aw=%h ar=%h w=%h s=%h want 0", aw_addr, ar_addr, w_data, w_strb); end
        n_cmp++; if ({aw_prot, ar_prot} !== 6'b0) begin n_err++; $display("FAIL prot: got %b want 000000", {aw_prot, ar_prot}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h1000;
        #1;
        n_cmp++; if (obi_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %0b want 1", obi_gnt); end
        step();                                   // t+1
        obi_req = 1'b0;
        n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 32'h1000) begin n_err++; $display("FAIL rd_ar: got v=%0b a=%h want 1/00001000", ar_valid, ar_addr); end
        n_cmp++; if (busy !== 1'b1 || outstanding !== 3'd1) begin n_err++; $display("FAIL rd_busy: got %0b/%0d want 1/1", busy, outstanding); end
        step();                                   // t+2
        r_valid = 1'b1; r_data = 32'hDEADBEEF; r_resp = 2'b00;
        n_cmp++; if (ar_valid !== 1'b0 || obi_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_t2: got ar=%0b rv=%0b want 0/0", ar_valid, obi_rvalid); end
        step();                                   // t+3
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hDEADBEEF || obi_err !== 1'b0) begin n_err++; $display("FAIL rd_resp: got rv=%0b d=%h e=%0b want 1/deadbeef/0", obi_rvalid, obi_rdata, obi_err); end
        n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL rd_cnt: got %0d want 0", outstanding); end
        step();
        n_cmp++; if (obi_rvalid !== 1'b0 || obi_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold: got rv=%0b d=%h want 0/deadbeef", obi_rvalid, obi_rdata); end
    endtask

    task automatic test_write_strobe();
        aw_ready = 1'b1; w_ready = 1'b0;
        obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h2004; obi_be = 4'b0110; obi_wdata = 32'hA5A5A5A5;
        #1;
        n_cmp++; if (obi_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %0b want 1", obi_gnt); end
        step();                                   // t+1
        obi_req = 1'b0;
        n_cmp++; if (aw_valid !== 1'b1 || w_valid !== 1'b1 || aw_addr !== 32'h2004) begin n_err++; $display("FAIL wr_valids: got aw=%0b w=%0b a=%h want 1/1/00002004", aw_valid, w_valid, aw_addr); end
        for (int j = 0; j < 3; j++) begin         // t+2 .. t+4, w_ready still low
            step();
            n_cmp++; if (aw_valid !== 1'b0 || w_valid !== 1'b1 || w_strb !== 4'b0110 || w_data !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_stall%0d: got aw=%0b w=%0b s=%b d=%h want 0/1/0110/a5a5a5a5", j, aw_valid, w_valid, w_strb, w_data); end
        end
        step();                                   // t+5
        w_ready = 1'b1;
        n_cmp++; if (obi_rvalid !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL wr_wait: got rv=%0b bready=%0b want 0/1", obi_rvalid, b_ready); end
        step();
        n_cmp++; if (w_valid !== 1'b0) begin n_err++; $display("FAIL wr_whs: got %0b want 0", w_valid); end
        b_valid = 1'b1; b_resp = 2'b00;
        step();
        b_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h0 || obi_err !== 1'b0) begin n_err++; $display("FAIL wr_resp: got rv=%0b d=%h e=%0b want 1/0/0", obi_rvalid, obi_rdata, obi_err); end
        step();
        n_cmp++; if (obi_rvalid !== 1'b0 || outstanding !== 3'd0) begin n_err++; $display("FAIL wr_once: got rv=%0b cnt=%0d want 0/0", obi_rvalid, outstanding); end
    endtask

    task automatic test_saturation();
        ar_ready = 1'b1; r_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h3000 + 32'(4 * i);
            #1;
            n_cmp++; if (obi_gnt !== (i < 4)) begin n_err++; $display("FAIL sat_gnt%0d: got %0b want %0b", i, obi_gnt, (i < 4)); end
            step();
        end
        #1;
        n_cmp++; if (outstanding !== 3'd4 || obi_gnt !== 1'b0) begin n_err++; $display("FAIL sat_full: got cnt=%0d gnt=%0b want 4/0", outstanding, obi_gnt); end
        r_valid = 1'b1; r_data = 32'h77; r_resp = 2'b00;
        #1;
        n_cmp++; if (obi_gnt !== 1'b0) begin n_err++; $display("FAIL sat_nobypass: got %0b want 0", obi_gnt); end
        step();
        r_valid = 1'b0;
        #1;
        n_cmp++; if (obi_gnt !== 1'b1 || outstanding !== 3'd3 || obi_rdata !== 32'h77) begin n_err++; $display("FAIL sat_regrant: got gnt=%0b cnt=%0d d=%h want 1/3/77", obi_gnt, outstanding, obi_rdata); end
        step();
        obi_req = 1'b0;
        n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL sat_refill: got %0d want 4", outstanding); end
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1; r_data = 32'h100 + 32'(k);
            step();
            n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h100 + 32'(k)) begin n_err++; $display("FAIL sat_drain%0d: got rv=%0b d=%h want 1/%h", k, obi_rvalid, obi_rdata, 32'h100 + 32'(k)); end
        end
        r_valid = 1'b0;
        n_cmp++; if (outstanding !== 3'd0 || busy !== 1'b0) begin n_err++; $display("FAIL sat_empty: got cnt=%0d busy=%0b want 0/0", outstanding, busy); end
        step();
    endtask

    task automatic test_ordering();
        aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1; obi_be = 4'hF;
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h4000;
        step();
        obi_we = 1'b1; obi_addr = 32'h4004; obi_wdata = 32'h11223344;
        step();
        obi_we = 1'b0; obi_addr = 32'h4008;
        step();
        obi_req = 1'b0;
        n_cmp++; if (outstanding !== 3'd3) begin n_err++; $display("FAIL ord_cnt: got %0d want 3", outstanding); end
        b_valid = 1'b1; b_resp = 2'b00;
        #1;
        n_cmp++; if (b_ready !== 1'b0 || r_ready !== 1'b1) begin n_err++; $display("FAIL ord_bstall: got b=%0b r=%0b want 0/1", b_ready, r_ready); end
        step();
        n_cmp++; if (b_ready !== 1'b0 || obi_rvalid !== 1'b0) begin n_err++; $display("FAIL ord_bstall2: got b=%0b rv=%0b want 0/0", b_ready, obi_rvalid); end
        r_valid = 1'b1; r_data = 32'hAAAA0001; r_resp = 2'b00;
        step();
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hAAAA0001 || b_ready !== 1'b1) begin n_err++; $display("FAIL ord_r1: got rv=%0b d=%h b=%0b want 1/aaaa0001/1", obi_rvalid, obi_rdata, b_ready); end
        step();
        b_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h0) begin n_err++; $display("FAIL ord_w: got rv=%0b d=%h want 1/0", obi_rvalid, obi_rdata); end
        r_valid = 1'b1; r_data = 32'hAAAA0003;
        step();
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hAAAA0003 || outstanding !== 3'd0) begin n_err++; $display("FAIL ord_r2: got rv=%0b d=%h cnt=%0d want 1/aaaa0003/0", obi_rvalid, obi_rdata, outstanding); end
        step();
    endtask

    task automatic test_errors();
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h7000;
        step();
        obi_req = 1'b0;
        r_valid = 1'b1; r_data = 32'h55; r_resp = 2'b10;
        step();
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== 32'h55) begin n_err++; $display("FAIL err_slv: got rv=%0b e=%0b d=%h want 1/1/55", obi_rvalid, obi_err, obi_rdata); end
        obi_req = 1'b1; obi_we = 1'b1; obi_addr = 32'h7004; obi_wdata = 32'h99;
        step();
        obi_req = 1'b0;
        b_valid = 1'b1; b_resp = 2'b11;
        step();
        b_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== 32'h0) begin n_err++; $display("FAIL err_dec: got rv=%0b e=%0b d=%h want 1/1/0", obi_rvalid, obi_err, obi_rdata); end
        step();
        n_cmp++; if (obi_rvalid !== 1'b0 || obi_err !== 1'b1) begin n_err++; $display("FAIL err_hold: got rv=%0b e=%0b want 0/1", obi_rvalid, obi_err); end
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h7008;
        step();
        obi_req = 1'b0;
        r_valid = 1'b1; r_data = 32'h66; r_resp = 2'b00;
        step();
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_err !== 1'b0 || obi_rdata !== 32'h66) begin n_err++; $display("FAIL err_okay: got rv=%0b e=%0b d=%h want 1/0/66", obi_rvalid, obi_err, obi_rdata); end
        step();
    endtask

    task automatic test_reset_midop();
        aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b1; r_valid = 1'b0;
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h5000;
        step();
        obi_addr = 32'h5004;
        step();
        obi_we = 1'b1; obi_addr = 32'h5008; obi_wdata = 32'h1234;
        step();
        obi_req = 1'b0;
        n_cmp++; if (outstanding !== 3'd3 || aw_valid !== 1'b1 || w_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre: got cnt=%0d aw=%0b w=%0b want 3/1/1", outstanding, aw_valid, w_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, obi_rvalid, busy} !== 7'b0) begin n_err++; $display("FAIL mid_rst_valids: got %b want 0000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, obi_rvalid, busy}); end
        n_cmp++; if (outstanding !== 3'd0 || obi_rdata !== 32'h0) begin n_err++; $display("FAIL mid_rst_cnt: got cnt=%0d d=%h want 0/0", outstanding, obi_rdata); end
        step();
        rst_n = 1'b1;
        aw_ready = 1'b1; w_ready = 1'b1;
        step();
        obi_req = 1'b1; obi_we = 1'b0; obi_addr = 32'h6000;
        #1;
        n_cmp++; if (obi_gnt !== 1'b1) begin n_err++; $display("FAIL mid_gnt: got %0b want 1", obi_gnt); end
        step();
        obi_req = 1'b0;
        n_cmp++; if (ar_valid !== 1'b1 || ar_addr !== 32'h6000 || outstanding !== 3'd1) begin n_err++; $display("FAIL mid_ar: got v=%0b a=%h cnt=%0d want 1/00006000/1", ar_valid, ar_addr, outstanding); end
        step();
        r_valid = 1'b1; r_data = 32'hCAFEF00D; r_resp = 2'b00;
        step();
        r_valid = 1'b0;
        n_cmp++; if (obi_rvalid !== 1'b1 || obi_rdata !== 32'hCAFEF00D || outstanding !== 3'd0) begin n_err++; $display("FAIL mid_resp: got rv=%0b d=%h cnt=%0d want 1/cafef00d/0", obi_rvalid, obi_rdata, outstanding); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        obi_req = 1'b0; obi_we = 1'b0; obi_addr = '0; obi_be = '0; obi_wdata = '0;
        aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
        b_valid = 1'b0; b_resp = '0; r_valid = 1'b0; r_data = '0; r_resp = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_write_strobe();
        test_saturation();
        test_ordering();
        test_errors();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
